// File: rtl/uart_pkg.sv
// UART shared definitions: receiver state encoding and bit helpers.
// Also used by the matching transmitter.
package uart_pkg;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t WAIT_IDLE = 3'd0;
  localparam rx_state_t IDLE      = 3'd1;
  localparam rx_state_t START     = 3'd2;
  localparam rx_state_t DATA      = 3'd3;
  localparam rx_state_t PARITY    = 3'd4;
  localparam rx_state_t STOP      = 3'd5;

  localparam int MAX_DATA_BITS = 9;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Error flag: data XOR received parity XOR odd-select.
  function automatic logic par_calc(
    input logic [MAX_DATA_BITS-1:0] d,
    input logic                     v,
    input logic                     odd
  );
    return (^d) ^ v ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer plus 3-tap majority vote for the UART receiver.
// Taps shift on the first two strobes; the third sample is live s_rx.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx_serial,
  input  logic tap,
  output logic s_rx,
  output logic vote
);

  logic sync1;
  logic sync2;
  logic [1:0] taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_serial;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= 2'b11;
    end else if (tap) begin
      taps <= {taps[0], sync2};
    end
  end

  assign s_rx = sync2;
  assign vote = maj3(taps[1], taps[0], sync2);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity,
// 1 or 2 stop bits, majority-voted bits, parity/frame/break status.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Rx_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int M  = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] M_LO     = CW'(M - 1);
  localparam logic [CW-1:0] M_MID    = CW'(M);
  localparam logic [CW-1:0] M_HI     = CW'(M + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic          LAST_STP = (STOP_BITS == 2);
  localparam logic          HAS_PAR  = (PARITY_EN != 0);
  localparam logic          ODD      = (PARITY_ODD != 0);

  rx_state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic stop_idx;
  logic [DATA_BITS-1:0] data;
  logic par_err;
  logic ferr;
  logic hi_seen;

  logic s_rx;
  logic vote;
  logic tap;
  logic at_mid;
  logic at_end;
  logic fin_err;

  assign o_Rx_Busy = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
  assign at_mid  = (cnt == M_HI);
  assign at_end  = (cnt == LAST_CNT);
  assign tap     = o_Rx_Busy && ((cnt == M_LO) || (cnt == M_MID));
  assign fin_err = ferr | ~vote;

  uart_rx_sampler u_sampler (
    .clk       (i_Clock),
    .rst_n     (i_Rst_L),
    .rx_serial (i_Rx_Serial),
    .tap       (tap),
    .s_rx      (s_rx),
    .vote      (vote)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= WAIT_IDLE;
      cnt          <= '0;
      idx          <= '0;
      stop_idx     <= 1'b0;
      data         <= '0;
      par_err      <= 1'b0;
      ferr         <= 1'b0;
      hi_seen      <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_Rx_DV <= 1'b0;
      case (state)
        WAIT_IDLE: begin
          if (!s_rx) begin
            cnt <= '0;
          end else if (at_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          cnt      <= '0;
          idx      <= '0;
          stop_idx <= 1'b0;
          par_err  <= 1'b0;
          ferr     <= 1'b0;
          hi_seen  <= 1'b0;
          if (!s_rx) begin
            state <= START;
          end
        end
        START: begin
          if (at_mid && vote) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (at_end) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (at_mid) begin
            data[idx] <= vote;
            hi_seen   <= hi_seen | vote;
          end
          if (at_end) begin
            cnt <= '0;
            if (idx != LAST_IDX) begin
              idx <= idx + 1'b1;
            end else if (HAS_PAR) begin
              state <= PARITY;
            end else begin
              state <= STOP;
            end
          end
        end
        PARITY: begin
          cnt <= cnt + 1'b1;
          if (at_mid) begin
            par_err <= par_calc(MAX_DATA_BITS'(data), vote, ODD);
            hi_seen <= hi_seen | vote;
          end
          if (at_end) begin
            cnt   <= '0;
            state <= STOP;
          end
        end
        STOP: begin
          cnt <= cnt + 1'b1;
          // Final stop completes at mid-bit to catch a back-to-back start.
          if (at_mid && (stop_idx == LAST_STP)) begin
            o_Rx_DV      <= 1'b1;
            o_Rx_Byte    <= data;
            o_Parity_Err <= HAS_PAR & par_err;
            o_Frame_Err  <= fin_err;
            o_Break      <= ~(hi_seen | vote);
            cnt          <= '0;
            state        <= fin_err ? WAIT_IDLE : IDLE;
          end else if (at_mid) begin
            ferr    <= fin_err;
            hi_seen <= hi_seen | vote;
          end else if (at_end) begin
            cnt      <= '0;
            stop_idx <= 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= WAIT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 9N2 instances
// share one clock; received words are logged and checked in order.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic tx;
  logic [1:0] sel;

  logic rx_a, rx_p, rx_n;
  logic dv_a, dv_p, dv_n;
  logic [7:0] byte_a, byte_p;
  logic [8:0] byte_n;
  logic pe_a, pe_p, pe_n;
  logic fe_a, fe_p, fe_n;
  logic brk_a, brk_p, brk_n;
  logic busy_a, busy_p, busy_n;

  int n_chk = 0;
  int n_err = 0;
  logic [13:0] q[$];

  always #5 clk = ~clk;

  assign rx_a = (sel == 2'd0) ? tx : 1'b1;
  assign rx_p = (sel == 2'd1) ? tx : 1'b1;
  assign rx_n = (sel == 2'd2) ? tx : 1'b1;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0),
                .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_a),
    .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a), .o_Parity_Err(pe_a),
    .o_Frame_Err(fe_a), .o_Break(brk_a), .o_Rx_Busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
                .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_p),
    .o_Rx_DV(dv_p), .o_Rx_Byte(byte_p), .o_Parity_Err(pe_p),
    .o_Frame_Err(fe_p), .o_Break(brk_p), .o_Rx_Busy(busy_p));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY_EN(0),
                .PARITY_ODD(0), .STOP_BITS(2)) dut_n (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Rx_Serial(rx_n),
    .o_Rx_DV(dv_n), .o_Rx_Byte(byte_n), .o_Parity_Err(pe_n),
    .o_Frame_Err(fe_n), .o_Break(brk_n), .o_Rx_Busy(busy_n));

  // Entry: {dut id, break, frame err, parity err, 9-bit word}
  always @(negedge clk) begin
    if (dv_a) q.push_back({2'd0, brk_a, fe_a, pe_a, 1'b0, byte_a});
    if (dv_p) q.push_back({2'd1, brk_p, fe_p, pe_p, 1'b0, byte_p});
    if (dv_n) q.push_back({2'd2, brk_n, fe_n, pe_n, byte_n});
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] mk(input logic [1:0] id,
    input logic b, input logic f, input logic p, input logic [8:0] d);
    return {id, b, f, p, d};
  endfunction

  task automatic expect_word(input string tag, input logic [13:0] exp);
    if (q.size() == 0) chk({tag, "_missing"}, 32'hdead, {18'd0, exp});
    else chk(tag, {18'd0, q.pop_front()}, {18'd0, exp});
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tx = 1'b1;
    end
  endtask

  task automatic send_bit(input logic b, input bit g);
    for (int c = 0; c < CPB; c++) begin
      @(negedge clk);
      tx = (g && c == 8) ? ~b : b;
    end
  endtask

  // pb < 0: no parity bit; gb: data bit carrying a 1-cycle glitch
  task automatic send_frame(input logic [8:0] d, input int nb,
    input int pb, input int ns, input int gb);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i], i == gb);
    if (pb >= 0) send_bit(pb[0], 1'b0);
    for (int i = 0; i < ns; i++) send_bit(1'b1, 1'b0);
  endtask

  initial begin
    tx = 1'b1;
    sel = 2'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dv", {31'd0, dv_a}, 0);
    chk("rst_byte", {24'd0, byte_a}, 0);
    chk("rst_flags", {29'd0, brk_a, fe_a, pe_a}, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_byte_n", {23'd0, byte_n}, 0);
    rst_n = 1'b1;
    idle(20);

    // Single 8N1 frame
    sel = 2'd0;
    send_frame(9'h055, 8, -1, 1, -1);
    idle(20);
    expect_word("8n1_55", mk(0, 0, 0, 0, 9'h055));
    chk("8n1_extra", q.size(), 0);

    // Even parity: correct bit then wrong bit
    sel = 2'd1;
    send_frame(9'h0A3, 8, 0, 1, -1);
    idle(20);
    send_frame(9'h0A3, 8, 1, 1, -1);
    idle(20);
    expect_word("par_ok", mk(1, 0, 0, 0, 9'h0A3));
    expect_word("par_bad", mk(1, 0, 0, 1, 9'h0A3));
    chk("par_extra", q.size(), 0);

    // False start from a short low glitch
    sel = 2'd0;
    repeat (3) begin
      @(negedge clk);
      tx = 1'b0;
    end
    idle(40);
    chk("fs_none", q.size(), 0);
    chk("fs_busy", {31'd0, busy_a}, 0);

    // Glitch at a data bit's mid sample
    send_frame(9'h096, 8, -1, 1, 3);
    idle(20);
    expect_word("glitch_96", mk(0, 0, 0, 0, 9'h096));
    chk("glitch_extra", q.size(), 0);

    // Break: line low for two frames
    for (int c = 0; c < 2 * 10 * CPB; c++) begin
      @(negedge clk);
      tx = 1'b0;
    end
    idle(40);
    expect_word("break", mk(0, 1, 1, 0, 9'h000));
    chk("break_once", q.size(), 0);
    send_frame(9'h05A, 8, -1, 1, -1);
    idle(20);
    expect_word("post_break", mk(0, 0, 0, 0, 9'h05A));

    // Reset during bit 4 of 0xF0, then resume the line
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tx = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_byte", {24'd0, byte_a}, 0);
    chk("mid_rst_busy", {31'd0, busy_a}, 0);
    chk("mid_rst_dv", {31'd0, dv_a}, 0);
    rst_n = 1'b1;
    for (int c = 0; c < CPB - 6; c++) begin
      @(negedge clk);
      tx = 1'b1;
    end
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(20);
    send_frame(9'h03C, 8, -1, 1, -1);
    idle(20);
    expect_word("rst_3c", mk(0, 0, 0, 0, 9'h03C));
    chk("rst_extra", q.size(), 0);

    // 9-bit, 2 stop bits, back to back
    sel = 2'd2;
    send_frame(9'h1FF, 9, -1, 2, -1);
    send_frame(9'h100, 9, -1, 2, -1);
    idle(20);
    expect_word("b2b_1ff", mk(2, 0, 0, 0, 9'h1FF));
    expect_word("b2b_100", mk(2, 0, 0, 0, 9'h100));
    chk("b2b_extra", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
